// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the register file's single write port between the WB stage
//          and the long-latency unit (LU). WB has default priority. A wait
//          counter bounds LU starvation by forcing one WB stall cycle.
//          A per-register pending scoreboard flags in-flight LU destinations
//          for decode RAW-hazard stalls.
// Latency: zero; write-port outputs are combinational from the current grant,
//          and the register file commits on the same rising edge.
// Backpressure: wb_ready drops only in FORCE. lu_ready rises only on an
//          LU grant. During reset every output is held low.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   wb_valid/wb_reg/wb_data      WB write request
//   wb_ready                     WB write accepted (pipeline freezes when low)
//   lu_valid/lu_reg/lu_data      LU result; held stable until lu_ready
//   lu_ready                     LU write accepted this cycle
//   lu_issue/lu_issue_reg        LU op issued; marks its destination pending
//   rs_addr/rt_addr              decode source registers
//   rs_busy/rt_busy              source has a pending LU write
//   WriteEnable/WriteReg/WriteData  register file write port
//
// Optional build macro REGFILE_ARB_STATS_EN adds the saturating 16-bit
// counters stat_wb_grants, stat_lu_grants and stat_forced.

module regfile_write_arbiter #(
    parameter int RL           = 5,
    parameter int DL           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          wb_valid,
    input  logic [RL-1:0] wb_reg,
    input  logic [DL-1:0] wb_data,
    output logic          wb_ready,

    input  logic          lu_valid,
    input  logic [RL-1:0] lu_reg,
    input  logic [DL-1:0] lu_data,
    output logic          lu_ready,

    input  logic          lu_issue,
    input  logic [RL-1:0] lu_issue_reg,

    input  logic [RL-1:0] rs_addr,
    input  logic [RL-1:0] rt_addr,
    output logic          rs_busy,
    output logic          rt_busy,

    output logic          WriteEnable,
    output logic [RL-1:0] WriteReg,
    output logic [DL-1:0] WriteData
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0]   stat_wb_grants,
    output logic [15:0]   stat_lu_grants,
    output logic [15:0]   stat_forced
`endif
);

    localparam int          NREGS   = 2 ** RL;
    localparam logic [3:0]  W_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_wait_cnt;
    logic [NREGS-1:0]   r_pend;

    logic               w_in_force;
    logic               w_lu_grant;
    logic               w_wb_ready;
    logic               w_wb_grant;
    logic               w_both;
    logic [3:0]         w_cnt_inc;
    logic               w_enter_force;
    logic [NREGS-1:0]   w_set_mask;
    logic [NREGS-1:0]   w_clr_mask;

    // ------------------------------------------------------------------
    // Grant decision. Outside FORCE, IDLE and WAIT grant the same way:
    // the LU wins only when WB has nothing to write, and WB is always
    // ready. The states differ only in how the wait counter advances.
    // ------------------------------------------------------------------
    assign w_in_force = (r_state == S_FORCE);
    assign w_lu_grant = !reset && lu_valid && (w_in_force || !wb_valid);
    assign w_wb_ready = !reset && !w_in_force;
    assign w_wb_grant = w_wb_ready && wb_valid;

    assign wb_ready   = w_wb_ready;
    assign lu_ready   = w_lu_grant;

    // Write-port mux. A grant to $zero still completes its handshake,
    // but it never raises WriteEnable.
    always_comb begin
        WriteEnable = 1'b0;
        WriteReg    = '0;
        WriteData   = '0;
        if (w_lu_grant) begin
            WriteEnable = (lu_reg != '0);
            WriteReg    = lu_reg;
            WriteData   = lu_data;
        end else if (w_wb_grant) begin
            WriteEnable = (wb_reg != '0);
            WriteReg    = wb_reg;
            WriteData   = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Starvation tracking. The first refusal (in IDLE) loads the counter
    // with 1. Each further refusal in WAIT increments it. The cycle on
    // which it reaches the limit moves the FSM into FORCE.
    // ------------------------------------------------------------------
    assign w_both        = lu_valid && wb_valid;
    assign w_cnt_inc     = (r_state == S_IDLE) ? 4'd1 : (r_wait_cnt + 4'd1);
    assign w_enter_force = !reset && w_both && !w_in_force && (w_cnt_inc >= W_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_both) begin
                        r_wait_cnt <= w_cnt_inc;
                        r_state    <= w_enter_force ? S_FORCE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Covers both an LU grant (WB idle) and an LU that
                    // withdrew its request (protocol violation).
                    if (!w_both) begin
                        r_wait_cnt <= 4'd0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                        r_state    <= w_enter_force ? S_FORCE : S_WAIT;
                    end
                end
                S_FORCE: begin
                    r_wait_cnt <= 4'd0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_wait_cnt <= 4'd0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard. A new issue to the same register as a
    // completing LU write means another op is now in flight, so set
    // overrides clear. Register 0 is never marked.
    // ------------------------------------------------------------------
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_set_mask[i] = lu_issue && (lu_issue_reg == RL'(i));
            w_clr_mask[i] = w_lu_grant && (lu_reg == RL'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
        end
    end

    assign rs_busy = !reset && (rs_addr != '0) && r_pend[rs_addr];
    assign rt_busy = !reset && (rt_addr != '0) && r_pend[rt_addr];

`ifdef REGFILE_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating event counters.
    // ------------------------------------------------------------------
    logic [15:0] r_stat_wb;
    logic [15:0] r_stat_lu;
    logic [15:0] r_stat_force;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_wb    <= 16'd0;
            r_stat_lu    <= 16'd0;
            r_stat_force <= 16'd0;
        end else begin
            if (w_wb_grant && (r_stat_wb != 16'hFFFF))
                r_stat_wb <= r_stat_wb + 16'd1;
            if (w_lu_grant && (r_stat_lu != 16'hFFFF))
                r_stat_lu <= r_stat_lu + 16'd1;
            if (w_enter_force && (r_stat_force != 16'hFFFF))
                r_stat_force <= r_stat_force + 16'd1;
        end
    end

    assign stat_wb_grants = r_stat_wb;
    assign stat_lu_grants = r_stat_lu;
    assign stat_forced    = r_stat_force;
`endif

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two requesters: the pipeline writeback (WB) stage and the long-latency unit (LU: mult/div, multi-cycle load).
- WB has default priority. LU starvation is bounded by a wait counter that forces one WB stall cycle.
- A per-register pending scoreboard tracks LU destinations so decode can stall on RAW hazards against in-flight LU results.
- Sits between WB/LU and the register file's WriteEnable/WriteReg/WriteData inputs.

Parameters:
- RL, 5, register address width (32 architectural registers).
- DL, 32, data width.
- STARVE_LIMIT, 4, consecutive cycles the LU may be refused before WB is forced to stall; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  WB has a write this cycle.
- wb_reg  in  RL  WB destination register.
- wb_data  in  DL  WB write data.
- wb_ready  out  1  WB write accepted; pipeline freezes while wb_valid=1 and wb_ready=0.
- lu_valid  in  1  LU result available; must hold lu_valid, lu_reg and lu_data stable until accepted.
- lu_reg  in  RL  LU destination register.
- lu_data  in  DL  LU result.
- lu_ready  out  1  LU write accepted this cycle.
- lu_issue  in  1  an LU op is issued this cycle.
- lu_issue_reg  in  RL  destination of the issued LU op.
- rs_addr, rt_addr  in  RL each  decode source registers.
- rs_busy, rt_busy  out  1 each  source has a pending LU write (combinational).
- WriteEnable  out  1  register file write enable.
- WriteReg  out  RL  register file write address.
- WriteData  out  DL  register file write data.

Behaviour:
- Write-port outputs are combinational from the current grant. The register file commits on the same rising edge, so there is zero added latency.
- A grant with reg==0 completes its handshake normally but drives WriteEnable=0, because $zero is never written.
- FSM states:
  - IDLE: no LU waiting.
  - WAIT: LU refused at least once.
  - FORCE: LU owns the port this cycle.
- IDLE:
  - If lu_valid and !wb_valid: grant LU (lu_ready=1) and stay in IDLE.
  - If lu_valid and wb_valid: grant WB, set wait_cnt=1 and go to WAIT.
  - Otherwise grant WB when wb_valid.
- WAIT:
  - If !wb_valid: grant LU, clear wait_cnt and go to IDLE.
  - If wb_valid: grant WB and increment wait_cnt.
  - When wait_cnt reaches STARVE_LIMIT at the clock edge, go to FORCE.
- FORCE:
  - Grant LU unconditionally; wb_ready=0 even when wb_valid=1.
  - Clear wait_cnt and go to IDLE.
- Exactly one of wb_ready/lu_ready grants per cycle.
- wb_ready=1 whenever wb_valid=0, outside FORCE.
- lu_ready=0 whenever lu_valid=0.
- If lu_valid drops in WAIT, which is a protocol violation, go to IDLE and clear wait_cnt.
- Scoreboard, 2**RL bits, pend[r]:
  - Set on lu_issue for lu_issue_reg.
  - Cleared on an LU grant for lu_reg.
  - If set and clear hit the same register in the same cycle, set wins (a new op was issued).
  - lu_issue_reg==0 is ignored.
- rs_busy = pend[rs_addr]; rt_busy = pend[rt_addr]. Address 0 always reads 0.
- Reset values: FSM=IDLE, wait_cnt=0, pend all zero. During reset all outputs are held low: wb_ready=0, lu_ready=0, WriteEnable=0.
- Reset asserted mid-WAIT or in FORCE aborts the pending LU grant; the LU must re-present after reset.

Optional Feature:
- Macro: REGFILE_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_wb_grants, stat_lu_grants and stat_forced, each 16 bits.
  - Each counter increments on its event: a WB grant, an LU grant, or entering FORCE.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Test Plan:
- Only WB: wb_valid=1, wb_reg=5, wb_data=32'hDEAD_BEEF → wb_ready=1, WriteEnable=1, WriteReg=5, WriteData=DEADBEEF. The register reads back the value the next cycle.
- Conflict: wb_valid and lu_valid both 1 for 1 cycle, then wb_valid=0 → cycle 0 grants WB, cycle 1 grants LU (lu_ready=1), and the FSM returns to IDLE.
- Starvation: wb_valid=1 continuously, lu_valid=1, STARVE_LIMIT=4 → WB is granted for 4 cycles, then in cycle 5 wb_ready=0, lu_ready=1 and WriteReg=lu_reg. WB resumes in cycle 6.
- Scoreboard:
  - Issue lu_issue_reg=8, then rs_addr=8 → rs_busy=1 until the LU grant for reg 8 clears it.
  - An issue and a grant of reg 8 in the same cycle leave rs_busy=1.
- $zero: a WB write with wb_reg=0 → wb_ready=1, WriteEnable=0. lu_issue_reg=0 → rs_busy stays 0 with rs_addr=0.
- Reset mid-operation: assert reset while in WAIT with wait_cnt=3 → wb_ready=0, lu_ready=0 and WriteEnable=0 during reset. The next cycle is IDLE with all pend bits 0 and no stale LU grant.
